// File: rtl/std_cache_pkg.sv
// Shared types and helpers for the standard data cache.
// Holds the MSHR state encoding and the line-address comparison helper.
package std_cache_pkg;

    localparam int unsigned DCACHE_NR_MSHR = 4;

    typedef enum logic [1:0] {
        MSHR_FREE     = 2'd0,
        MSHR_PENDING  = 2'd1,
        MSHR_INFLIGHT = 2'd2
    } mshr_state_e;

    // Addresses are widened to 64 bits by the caller; offset bits are shifted out.
    function automatic logic line_match(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned offset);
        return (a >> offset) == (b >> offset);
    endfunction

endpackage

// File: rtl/std_cache_mshr_order_q.sv
// Circular FIFO of MSHR slot indices recording allocation order.
// Depth equals the slot count, so pushes bounded by free slots cannot overflow.
module std_cache_mshr_order_q #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [$clog2(DEPTH)-1:0] push_idx,
    input  logic                     pop,
    output logic                     empty,
    output logic [$clog2(DEPTH)-1:0] head_idx
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] slot_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   cnt_r;

    assign empty    = (cnt_r == '0);
    assign head_idx = slot_r[rd_ptr_r];

    // Storage, pointers and fill count; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            if (push) begin
                slot_r[wr_ptr_r] <= push_idx;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            cnt_r <= cnt_r + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

endmodule

// File: rtl/std_cache_mshr_file.sv
// N-entry miss-status holding register file: conflict-checked allocation,
// oldest-first issue and indexed completion. Optional STD_CACHE_MSHR_PERF_EN adds perf counters.
module std_cache_mshr_file
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = DCACHE_NR_MSHR,
    parameter int unsigned ADDR_WIDTH  = 56,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned LINE_OFFSET = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [ID_WIDTH-1:0]           alloc_id_i,
    input  logic                          alloc_we_i,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr_i,
    input  logic [DATA_WIDTH-1:0]         alloc_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       alloc_be_i,
    output logic [$clog2(NR_ENTRIES)-1:0] alloc_idx_o,
    input  logic [ADDR_WIDTH-1:0]         lookup_addr_i,
    output logic                          lookup_hit_o,
    output logic [$clog2(NR_ENTRIES)-1:0] lookup_idx_o,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [$clog2(NR_ENTRIES)-1:0] issue_idx_o,
    output logic [ADDR_WIDTH-1:0]         issue_addr_o,
    output logic                          issue_we_o,
    output logic [DATA_WIDTH-1:0]         issue_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       issue_be_o,
    input  logic                          complete_valid_i,
    input  logic [$clog2(NR_ENTRIES)-1:0] complete_idx_i,
`ifdef STD_CACHE_MSHR_PERF_EN
    output logic [31:0]                   perf_stall_cnt_o,
    output logic [$clog2(NR_ENTRIES):0]   perf_max_occ_o,
`endif
    output logic                          rsp_valid_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic                          rsp_we_o
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } entry_t;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NR_ENTRIES-1:0] vec);
        lowest_idx = '0;
        for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    entry_t      entry_r [NR_ENTRIES];
    mshr_state_e state_r [NR_ENTRIES];
    logic        run_r;
    logic        rsp_valid_r;
    logic [ID_WIDTH-1:0] rsp_id_r;
    logic        rsp_we_r;

    logic [NR_ENTRIES-1:0] free_vec_s;
    logic [NR_ENTRIES-1:0] conflict_vec_s;
    logic [NR_ENTRIES-1:0] lookup_vec_s;
    logic [IDX_W-1:0]      free_idx_s;
    logic [IDX_W-1:0]      head_idx_s;
    logic                  q_empty_s;
    logic                  alloc_fire_s;
    logic                  issue_fire_s;
    logic                  complete_hit_s;
    entry_t                alloc_entry_s;
    entry_t                head_entry_s;

    // Per-slot free / line-conflict / probe-hit vectors from registered state only.
    always_comb begin
        free_vec_s     = '0;
        conflict_vec_s = '0;
        lookup_vec_s   = '0;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            free_vec_s[i]     = (state_r[i] == MSHR_FREE);
            conflict_vec_s[i] = !free_vec_s[i] &&
                                line_match(64'(alloc_addr_i), 64'(entry_r[i].addr), LINE_OFFSET);
            lookup_vec_s[i]   = !free_vec_s[i] &&
                                line_match(64'(lookup_addr_i), 64'(entry_r[i].addr), LINE_OFFSET);
        end
    end

    assign free_idx_s     = lowest_idx(free_vec_s);
    assign alloc_idx_o    = free_idx_s;
    assign alloc_ready_o  = run_r && (|free_vec_s) && !(|conflict_vec_s);
    assign lookup_hit_o   = |lookup_vec_s;
    assign lookup_idx_o   = lowest_idx(lookup_vec_s);
    assign alloc_fire_s   = alloc_valid_i && alloc_ready_o;
    assign issue_valid_o  = !q_empty_s;
    assign issue_fire_s   = issue_valid_o && issue_ready_i;
    assign complete_hit_s = complete_valid_i && (state_r[complete_idx_i] == MSHR_INFLIGHT);
    assign head_entry_s   = entry_r[head_idx_s];
    assign alloc_entry_s  = '{id: alloc_id_i, we: alloc_we_i, addr: alloc_addr_i,
                              wdata: alloc_wdata_i, be: alloc_be_i};

    std_cache_mshr_order_q #(.DEPTH(NR_ENTRIES)) u_order_q (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (alloc_fire_s),
        .push_idx (free_idx_s),
        .pop      (issue_fire_s),
        .empty    (q_empty_s),
        .head_idx (head_idx_s)
    );

    // Issue payload is forced to zero whenever nothing is offered.
    always_comb begin
        if (issue_valid_o) begin
            issue_idx_o   = head_idx_s;
            issue_addr_o  = head_entry_s.addr;
            issue_we_o    = head_entry_s.we;
            issue_wdata_o = head_entry_s.wdata;
            issue_be_o    = head_entry_s.be;
        end else begin
            issue_idx_o   = '0;
            issue_addr_o  = '0;
            issue_we_o    = 1'b0;
            issue_wdata_o = '0;
            issue_be_o    = '0;
        end
    end

    // Slot state transitions; alloc, issue and complete always target distinct states.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_r <= 1'b0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                state_r[i] <= MSHR_FREE;
                entry_r[i] <= '0;
            end
        end else begin
            run_r <= 1'b1;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                if (alloc_fire_s && (free_idx_s == IDX_W'(i))) begin
                    state_r[i] <= MSHR_PENDING;
                    entry_r[i] <= alloc_entry_s;
                end else if (issue_fire_s && (head_idx_s == IDX_W'(i))) begin
                    state_r[i] <= MSHR_INFLIGHT;
                end else if (complete_hit_s && (complete_idx_i == IDX_W'(i))) begin
                    state_r[i] <= MSHR_FREE;
                end
            end
        end
    end

    // Completion response, one cycle after a valid completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_we_r    <= 1'b0;
        end else begin
            rsp_valid_r <= complete_hit_s;
            rsp_id_r    <= complete_hit_s ? entry_r[complete_idx_i].id : '0;
            rsp_we_r    <= complete_hit_s ? entry_r[complete_idx_i].we : 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_id_o    = rsp_id_r;
    assign rsp_we_o    = rsp_we_r;

`ifdef STD_CACHE_MSHR_PERF_EN
    logic [31:0]    stall_cnt_r;
    logic [IDX_W:0] max_occ_r;
    logic [IDX_W:0] occ_s;

    // Count of busy slots in the current registered state.
    always_comb begin
        occ_s = '0;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            occ_s = occ_s + (IDX_W+1)'(!free_vec_s[i]);
        end
    end

    // Saturating stall counter and occupancy high-water mark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'd0;
            max_occ_r   <= '0;
        end else begin
            if (alloc_valid_i && !alloc_ready_o && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (occ_s > max_occ_r) begin
                max_occ_r <= occ_s;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_r;
    assign perf_max_occ_o   = max_occ_r;
`endif

endmodule

// File: tb/tb_std_cache_mshr_file.sv
// Directed self-checking bench for std_cache_mshr_file (default 4 entries, 16-byte lines).
module tb_std_cache_mshr_file;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [1:0]  alloc_id_i;
    logic        alloc_we_i;
    logic [55:0] alloc_addr_i;
    logic [63:0] alloc_wdata_i;
    logic [7:0]  alloc_be_i;
    logic [1:0]  alloc_idx_o;
    logic [55:0] lookup_addr_i;
    logic        lookup_hit_o;
    logic [1:0]  lookup_idx_o;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [1:0]  issue_idx_o;
    logic [55:0] issue_addr_o;
    logic        issue_we_o;
    logic [63:0] issue_wdata_o;
    logic [7:0]  issue_be_o;
    logic        complete_valid_i;
    logic [1:0]  complete_idx_i;
    logic        rsp_valid_o;
    logic [1:0]  rsp_id_o;
    logic        rsp_we_o;
`ifdef STD_CACHE_MSHR_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [2:0]  perf_max_occ_o;
`endif

    int tests = 0;
    int fails = 0;

    std_cache_mshr_file dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_id_i(alloc_id_i), .alloc_we_i(alloc_we_i), .alloc_addr_i(alloc_addr_i),
        .alloc_wdata_i(alloc_wdata_i), .alloc_be_i(alloc_be_i), .alloc_idx_o(alloc_idx_o),
        .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o), .lookup_idx_o(lookup_idx_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_idx_o(issue_idx_o),
        .issue_addr_o(issue_addr_o), .issue_we_o(issue_we_o), .issue_wdata_o(issue_wdata_o),
        .issue_be_o(issue_be_o), .complete_valid_i(complete_valid_i),
        .complete_idx_i(complete_idx_i),
`ifdef STD_CACHE_MSHR_PERF_EN
        .perf_stall_cnt_o(perf_stall_cnt_o), .perf_max_occ_o(perf_max_occ_o),
`endif
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_we_o(rsp_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid_i    = 1'b0;
        alloc_id_i       = 2'd0;
        alloc_we_i       = 1'b0;
        alloc_addr_i     = 56'd0;
        alloc_wdata_i    = 64'd0;
        alloc_be_i       = 8'd0;
        lookup_addr_i    = 56'd0;
        issue_ready_i    = 1'b0;
        complete_valid_i = 1'b0;
        complete_idx_i   = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic alloc_one(input logic [55:0] addr, input logic [1:0] id, input logic we);
        alloc_valid_i = 1'b1;
        alloc_addr_i  = addr;
        alloc_id_i    = id;
        alloc_we_i    = we;
        alloc_wdata_i = {8{addr[7:0]}};
        alloc_be_i    = 8'hF0;
        tick();
        alloc_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tests++;
        if ({alloc_ready_o, issue_valid_o, lookup_hit_o, rsp_valid_o, alloc_idx_o} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {alloc_ready_o, issue_valid_o, lookup_hit_o, rsp_valid_o, alloc_idx_o});
        end
        rst_ni = 1'b1;
        tick();
        tests++;
        if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
            fails++;
            $display("FAIL post_reset_ready: got ready=%b idx=%0d expected ready=1 idx=0",
                     alloc_ready_o, alloc_idx_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 56'h1000;
        alloc_id_i    = 2'd1;
        alloc_we_i    = 1'b0;
        #1;
        tests++;
        if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
            fails++;
            $display("FAIL basic_alloc: got ready=%b idx=%0d expected ready=1 idx=0",
                     alloc_ready_o, alloc_idx_o);
        end
        tick();
        alloc_valid_i = 1'b0;
        #1;
        tests++;
        if (issue_valid_o !== 1'b1 || issue_idx_o !== 2'd0 || issue_addr_o !== 56'h1000) begin
            fails++;
            $display("FAIL basic_issue: got v=%b idx=%0d addr=%0h expected v=1 idx=0 addr=1000",
                     issue_valid_o, issue_idx_o, issue_addr_o);
        end
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        #1;
        tests++;
        if (issue_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_pop: got issue_valid=%b expected 0", issue_valid_o);
        end
        complete_valid_i = 1'b1;
        complete_idx_i   = 2'd0;
        tick();
        complete_valid_i = 1'b0;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_we_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_rsp: got v=%b id=%0d we=%b expected v=1 id=1 we=0",
                     rsp_valid_o, rsp_id_o, rsp_we_o);
        end
        tick();
        tests++;
        if (rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_rsp_pulse: got rsp_valid=%b expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        alloc_one(56'h1000, 2'd2, 1'b1);
        tests++;
        if (issue_we_o !== 1'b1 || issue_wdata_o !== 64'h0000_0000_0000_0000 || issue_be_o !== 8'hF0) begin
            fails++;
            $display("FAIL conflict_payload: got we=%b wdata=%0h be=%0h expected we=1 wdata=0 be=f0",
                     issue_we_o, issue_wdata_o, issue_be_o);
        end
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 56'h1008;
        alloc_id_i    = 2'd3;
        lookup_addr_i = 56'h1008;
        #1;
        tests++;
        if (alloc_ready_o !== 1'b0 || lookup_hit_o !== 1'b1 || lookup_idx_o !== 2'd0) begin
            fails++;
            $display("FAIL conflict_block: got ready=%b hit=%b idx=%0d expected ready=0 hit=1 idx=0",
                     alloc_ready_o, lookup_hit_o, lookup_idx_o);
        end
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i    = 1'b0;
        complete_valid_i = 1'b1;
        complete_idx_i   = 2'd0;
        #1;
        tests++;
        if (alloc_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL conflict_no_comb_free: got ready=%b expected 0", alloc_ready_o);
        end
        tick();
        complete_valid_i = 1'b0;
        #1;
        tests++;
        if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0 || lookup_hit_o !== 1'b0) begin
            fails++;
            $display("FAIL conflict_release: got ready=%b idx=%0d hit=%b expected ready=1 idx=0 hit=0",
                     alloc_ready_o, alloc_idx_o, lookup_hit_o);
        end
        alloc_valid_i = 1'b0;
    endtask

    task automatic test_full_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid_i = 1'b1;
            alloc_addr_i  = 56'(i * 16);
            alloc_id_i    = 2'(i);
            alloc_we_i    = 1'b0;
            #1;
            tests++;
            if (alloc_idx_o !== 2'(i) || alloc_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL fill_idx: got idx=%0d ready=%b expected idx=%0d ready=1",
                         alloc_idx_o, alloc_ready_o, i);
            end
            tick();
        end
        alloc_addr_i = 56'h40;
        #1;
        tests++;
        if (alloc_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL full_ready: got %b expected 0", alloc_ready_o);
        end
        alloc_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (issue_valid_o !== 1'b1 || issue_idx_o !== 2'd0) begin
                fails++;
                $display("FAIL hold_head: got v=%b idx=%0d expected v=1 idx=0",
                         issue_valid_o, issue_idx_o);
            end
        end
        issue_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (issue_idx_o !== 2'(i) || issue_addr_o !== 56'(i * 16)) begin
                fails++;
                $display("FAIL issue_order: got idx=%0d addr=%0h expected idx=%0d addr=%0h",
                         issue_idx_o, issue_addr_o, i, i * 16);
            end
            tick();
        end
        issue_ready_i = 1'b0;
        #1;
        tests++;
        if (issue_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL drained: got issue_valid=%b expected 0", issue_valid_o);
        end
        complete_valid_i = 1'b1;
        complete_idx_i   = 2'd2;
        tick();
        #1;
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2) begin
            fails++;
            $display("FAIL complete2: got v=%b id=%0d expected v=1 id=2", rsp_valid_o, rsp_id_o);
        end
        tick();
        complete_valid_i = 1'b0;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL complete2_again: got v=%b expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        alloc_one(56'h100, 2'd1, 1'b0);
        alloc_one(56'h200, 2'd2, 1'b1);
        alloc_one(56'h300, 2'd3, 1'b0);
        issue_ready_i = 1'b1;
        tick();
        alloc_valid_i    = 1'b1;
        alloc_addr_i     = 56'h400;
        alloc_id_i       = 2'd0;
        alloc_we_i       = 1'b1;
        complete_valid_i = 1'b1;
        complete_idx_i   = 2'd0;
        #1;
        tests++;
        if (alloc_idx_o !== 2'd3 || alloc_ready_o !== 1'b1 || issue_idx_o !== 2'd1) begin
            fails++;
            $display("FAIL simul_setup: got aidx=%0d ready=%b iidx=%0d expected aidx=3 ready=1 iidx=1",
                     alloc_idx_o, alloc_ready_o, issue_idx_o);
        end
        tick();
        alloc_valid_i    = 1'b0;
        issue_ready_i    = 1'b0;
        complete_valid_i = 1'b0;
        lookup_addr_i    = 56'h100;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || alloc_idx_o !== 2'd0 || lookup_hit_o !== 1'b0) begin
            fails++;
            $display("FAIL simul_result: got rsp=%b id=%0d aidx=%0d hit=%b expected rsp=1 id=1 aidx=0 hit=0",
                     rsp_valid_o, rsp_id_o, alloc_idx_o, lookup_hit_o);
        end
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        #1;
        tests++;
        if (issue_idx_o !== 2'd3 || issue_addr_o !== 56'h400 || issue_we_o !== 1'b1) begin
            fails++;
            $display("FAIL simul_slot3: got idx=%0d addr=%0h we=%b expected idx=3 addr=400 we=1",
                     issue_idx_o, issue_addr_o, issue_we_o);
        end
        complete_valid_i = 1'b1;
        complete_idx_i   = 2'd1;
        tick();
        complete_valid_i = 1'b0;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_we_o !== 1'b1) begin
            fails++;
            $display("FAIL simul_slot1_inflight: got v=%b id=%0d we=%b expected v=1 id=2 we=1",
                     rsp_valid_o, rsp_id_o, rsp_we_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_one(56'h500, 2'd1, 1'b0);
        alloc_one(56'h600, 2'd2, 1'b0);
        alloc_one(56'h700, 2'd3, 1'b0);
        lookup_addr_i = 56'h600;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({alloc_ready_o, issue_valid_o, lookup_hit_o, rsp_valid_o} !== 4'b0 ||
            issue_addr_o !== 56'd0 || issue_idx_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid: got ready=%b iv=%b hit=%b rsp=%b addr=%0h expected all 0",
                     alloc_ready_o, issue_valid_o, lookup_hit_o, rsp_valid_o, issue_addr_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        tests++;
        if (alloc_idx_o !== 2'd0 || issue_valid_o !== 1'b0 || alloc_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got idx=%0d iv=%b ready=%b expected idx=0 iv=0 ready=1",
                     alloc_idx_o, issue_valid_o, alloc_ready_o);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_conflict();
        test_full_order();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
